// File: rtl/dvi_pattern_scheduler.sv
// Frame-synchronous test-pattern source between the VESA timing generator and the DVI encoder.
// Syncs and a 24-bit RGB pattern are registered together, so every output lags its input by one.
module dvi_pattern_scheduler #(
    parameter int unsigned H_ACTIVE           = 1280,
    parameter int unsigned BAR_W              = 160,
    parameter int unsigned FRAMES_PER_PATTERN = 120,
    parameter int unsigned CHK_SHIFT          = 5,
    parameter bit          VS_ACTIVE          = 1'b1
) (
    input  logic        pix_clk,
    input  logic        rst_n,
    input  logic        vsync_i,
    input  logic        hsync_i,
    input  logic        de_i,
    input  logic [10:0] column_i,
    input  logic [10:0] row_i,
    input  logic        auto_en,
    input  logic        next_req,
    output logic        vsync_o,
    output logic        hsync_o,
    output logic        de_o,
    output logic [7:0]  red_o,
    output logic [7:0]  green_o,
    output logic [7:0]  blue_o,
    output logic [2:0]  pattern_id
);

    localparam int unsigned FrameCntW = (FRAMES_PER_PATTERN > 1) ? $clog2(FRAMES_PER_PATTERN) : 1;
    localparam int unsigned BarCntW   = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [FrameCntW-1:0] FrameLast = FrameCntW'(FRAMES_PER_PATTERN - 1);
    localparam logic [BarCntW-1:0]   BarLast   = BarCntW'(BAR_W - 1);
    localparam logic [10:0]          LineLast  = 11'(H_ACTIVE - 1);

    localparam logic [2:0] PatBars    = 3'd0;
    localparam logic [2:0] PatGrey    = 3'd1;
    localparam logic [2:0] PatChecker = 3'd2;
    localparam logic [2:0] PatWhite   = 3'd3;
    localparam logic [2:0] PatLine    = 3'd4;

    typedef enum logic [1:0] {StWaitSync, StRun, StSwitch} state_e;

    state_e               state_q, state_d;
    logic                 vsync_q, hsync_q, de_q;
    logic [23:0]          rgb_q, rgb_d, pix;
    logic [2:0]           pattern_q, pattern_d, pattern_inc;
    logic [FrameCntW-1:0] frame_cnt_q, frame_cnt_d;
    logic [10:0]          line_pos_q, line_pos_d;
    logic                 pending_q, pending_d;
    logic [BarCntW-1:0]   bar_cnt_q, bar_cnt_d;
    logic [2:0]           bar_idx_q, bar_idx_d;
    logic                 fs, auto_hit, unused_row;

    // Only the checkerboard bit of row_i is consumed.
    assign unused_row = ^row_i;

    assign fs          = (vsync_i == VS_ACTIVE) && (vsync_q != VS_ACTIVE);
    assign auto_hit    = auto_en && (frame_cnt_q == FrameLast);
    assign pattern_inc = (pattern_q == PatLine) ? 3'd0 : pattern_q + 3'd1;

    always_comb begin
        state_d     = state_q;
        pattern_d   = pattern_q;
        frame_cnt_d = frame_cnt_q;
        line_pos_d  = line_pos_q;
        pending_d   = pending_q | next_req;
        unique case (state_q)
            StWaitSync: begin
                if (fs) state_d = StRun;
            end
            StRun: begin
                if (fs) begin
                    if (pending_q || next_req || auto_hit) begin
                        state_d   = StSwitch;
                        pending_d = 1'b1;
                    end
                    if (frame_cnt_q != FrameLast) frame_cnt_d = frame_cnt_q + FrameCntW'(1);
                    if (pattern_q == PatLine) begin
                        line_pos_d = (line_pos_q == LineLast) ? 11'd0 : line_pos_q + 11'd1;
                    end
                end
            end
            StSwitch: begin
                state_d     = StRun;
                pattern_d   = pattern_inc;
                frame_cnt_d = '0;
                pending_d   = next_req;
                if (pattern_inc == PatLine) line_pos_d = '0;
            end
            default: state_d = StWaitSync;
        endcase
    end

    // Bar position is counted in data-enable cycles, independent of column_i.
    always_comb begin
        bar_cnt_d = '0;
        bar_idx_d = '0;
        if (de_i) begin
            if (bar_cnt_q == BarLast) begin
                bar_cnt_d = '0;
                bar_idx_d = bar_idx_q + 3'd1;
            end else begin
                bar_cnt_d = bar_cnt_q + BarCntW'(1);
                bar_idx_d = bar_idx_q;
            end
        end
    end

    always_comb begin
        pix = '0;
        unique case (pattern_q)
            PatBars:    pix = {{8{bar_idx_q[2]}}, {8{bar_idx_q[1]}}, {8{bar_idx_q[0]}}};
            PatGrey:    pix = {3{column_i[9:2]}};
            PatChecker: pix = (column_i[CHK_SHIFT] ^ row_i[CHK_SHIFT]) ? 24'hFF_FFFF : 24'h0;
            PatWhite:   pix = 24'hFF_FFFF;
            PatLine:    pix = (column_i == line_pos_q) ? 24'hFF_FFFF : 24'h0;
            default:    pix = '0;
        endcase
        rgb_d = (de_i && (state_q != StWaitSync)) ? pix : 24'h0;
    end

    always_ff @(posedge pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StWaitSync;
            vsync_q     <= 1'b0;
            hsync_q     <= 1'b0;
            de_q        <= 1'b0;
            rgb_q       <= '0;
            pattern_q   <= PatBars;
            frame_cnt_q <= '0;
            line_pos_q  <= '0;
            pending_q   <= 1'b0;
            bar_cnt_q   <= '0;
            bar_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            vsync_q     <= vsync_i;
            hsync_q     <= hsync_i;
            de_q        <= de_i;
            rgb_q       <= rgb_d;
            pattern_q   <= pattern_d;
            frame_cnt_q <= frame_cnt_d;
            line_pos_q  <= line_pos_d;
            pending_q   <= pending_d;
            bar_cnt_q   <= bar_cnt_d;
            bar_idx_q   <= bar_idx_d;
        end
    end

    assign vsync_o    = vsync_q;
    assign hsync_o    = hsync_q;
    assign de_o       = de_q;
    assign red_o      = rgb_q[23:16];
    assign green_o    = rgb_q[15:8];
    assign blue_o     = rgb_q[7:0];
    assign pattern_id = pattern_q;

endmodule

// File: tb/tb_dvi_pattern_scheduler.sv
// Bench for dvi_pattern_scheduler: synthetic frame timing, random requests, frame-level model.
// Each tick predicts the registered outputs from the inputs applied in that cycle.
module tb_dvi_pattern_scheduler;

    localparam int unsigned H_ACTIVE  = 8;
    localparam int unsigned BAR_W     = 160;
    localparam int unsigned FPP       = 2;
    localparam int unsigned CHK_SHIFT = 5;

    logic        pix_clk = 1'b0;
    logic        rst_n;
    logic        vsync_i, hsync_i, de_i, auto_en, next_req;
    logic [10:0] column_i, row_i;
    logic        vsync_o, hsync_o, de_o;
    logic [7:0]  red_o, green_o, blue_o;
    logic [2:0]  pattern_id;
    logic [29:0] dut_bus, exp_bus;
    logic [23:0] dut_rgb;

    int vectors = 0;
    int errors  = 0;
    int h_act, v_act, h_tot, v_tot;

    // Reference model state: frame-level view of the scheduler.
    bit m_started, m_pending, m_switch_next, m_vs_prev;
    int m_pid, m_frames, m_line, m_run;

    dvi_pattern_scheduler #(
        .H_ACTIVE           (H_ACTIVE),
        .BAR_W              (BAR_W),
        .FRAMES_PER_PATTERN (FPP),
        .CHK_SHIFT          (CHK_SHIFT),
        .VS_ACTIVE          (1'b1)
    ) dut (
        .pix_clk    (pix_clk),
        .rst_n      (rst_n),
        .vsync_i    (vsync_i),
        .hsync_i    (hsync_i),
        .de_i       (de_i),
        .column_i   (column_i),
        .row_i      (row_i),
        .auto_en    (auto_en),
        .next_req   (next_req),
        .vsync_o    (vsync_o),
        .hsync_o    (hsync_o),
        .de_o       (de_o),
        .red_o      (red_o),
        .green_o    (green_o),
        .blue_o     (blue_o),
        .pattern_id (pattern_id)
    );

    assign dut_bus = {vsync_o, hsync_o, de_o, red_o, green_o, blue_o, pattern_id};
    assign dut_rgb = {red_o, green_o, blue_o};

    always #5 pix_clk = ~pix_clk;

    function automatic logic [23:0] ref_pixel(int pid, int c, int r, int run, int line);
        int idx;
        logic [7:0] g;
        case (pid)
            0: begin
                idx = (run / BAR_W) % 8;
                return {{8{idx[2]}}, {8{idx[1]}}, {8{idx[0]}}};
            end
            1: begin
                g = 8'((c >> 2) & 255);
                return {g, g, g};
            end
            2: return ((((c >> CHK_SHIFT) ^ (r >> CHK_SHIFT)) & 1) != 0) ? 24'hFFFFFF : 24'h0;
            3: return 24'hFFFFFF;
            4: return (c == line) ? 24'hFFFFFF : 24'h0;
            default: return 24'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_started = 0; m_pending = 0; m_switch_next = 0; m_vs_prev = 0;
        m_pid = 0; m_frames = 0; m_line = 0; m_run = 0;
    endtask

    task automatic set_geom(input int ha, input int va);
        h_act = ha; v_act = va; h_tot = ha + 4; v_tot = va + 3;
    endtask

    // Lines: active, front porch, vsync, back porch; hsync two cycles after active.
    task automatic set_timing(input int k);
        int line, x;
        line     = k / h_tot;
        x        = k % h_tot;
        de_i     = (line < v_act) && (x < h_act);
        column_i = de_i ? 11'(x) : 11'd0;
        row_i    = de_i ? 11'(line) : 11'd0;
        hsync_i  = (x == h_act + 1) || (x == h_act + 2);
        vsync_i  = (line == v_act + 1);
    endtask

    task automatic tick();
        bit fs;
        logic [23:0] rgb;
        fs  = vsync_i && !m_vs_prev;
        rgb = (de_i && m_started) ? ref_pixel(m_pid, column_i, row_i, m_run, m_line) : 24'h0;
        m_run     = de_i ? m_run + 1 : 0;
        m_vs_prev = vsync_i;
        if (m_switch_next) begin
            m_pid = (m_pid + 1) % 5;
            m_frames = 0;
            m_pending = next_req;
            m_switch_next = 0;
            if (m_pid == 4) m_line = 0;
        end else begin
            if (next_req) m_pending = 1;
            if (fs && m_started) begin
                if (m_pending || (auto_en && m_frames == FPP - 1)) m_switch_next = 1;
                if (m_frames < FPP - 1) m_frames++;
                if (m_pid == 4) m_line = (m_line + 1) % H_ACTIVE;
            end else if (fs) begin
                m_started = 1;
            end
        end
        exp_bus = {vsync_i, hsync_i, de_i, rgb, 3'(m_pid)};
        @(posedge pix_clk);
        #1;
    endtask

    task automatic do_reset();
        vsync_i = 0; hsync_i = 0; de_i = 0; column_i = 0; row_i = 0; next_req = 0;
        rst_n = 1'b0;
        @(posedge pix_clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        @(posedge pix_clk);
        #1;
        vectors++;
        if (dut_bus !== 30'h0) begin
            errors++; $display("FAIL reset_initial got %h exp 0", dut_bus);
        end
        vsync_i = 1; hsync_i = 1; de_i = 1; next_req = 1;
        column_i = 11'($urandom_range(0, 1279));
        @(posedge pix_clk);
        #1;
        vectors++;
        if (dut_bus !== 30'h0) begin
            errors++; $display("FAIL reset_held got %h exp 0", dut_bus);
        end
        vsync_i = 0; hsync_i = 0; de_i = 0; next_req = 0; column_i = 0;
        rst_n = 1'b1;
        model_reset();
        tick();
        vectors++;
        if (dut_bus !== exp_bus) begin
            errors++; $display("FAIL reset_release got %h exp %h", dut_bus, exp_bus);
        end
    endtask

    task automatic test_bars();
        logic [23:0] want;
        set_geom(1280, 2);
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < h_tot * v_tot; k++) begin
                set_timing(k);
                tick();
                vectors++;
                if (dut_bus !== exp_bus) begin
                    errors++; $display("FAIL bars f=%0d k=%0d got %h exp %h", f, k, dut_bus, exp_bus);
                end
                if (de_i && row_i == 0 && (column_i == 0 || column_i == 160 || column_i == 1279)) begin
                    want = (f == 0 || column_i == 0) ? 24'h0 :
                           (column_i == 160) ? 24'h0000FF : 24'hFFFFFF;
                    vectors++;
                    if (dut_rgb !== want || pattern_id !== 3'd0) begin
                        errors++;
                        $display("FAIL bars_pixel f=%0d c=%0d got %h/%0d exp %h/0",
                                 f, column_i, dut_rgb, pattern_id, want);
                    end
                end
            end
        end
    endtask

    task automatic test_next_req();
        int kreq, kfs;
        set_geom(512, 2);
        kfs  = (v_act + 1) * h_tot;
        kreq = $urandom_range(0, v_act * h_tot - 1);
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < h_tot * v_tot; k++) begin
                set_timing(k);
                next_req = (f == 0) && (k == kreq);
                tick();
                vectors++;
                if (dut_bus !== exp_bus) begin
                    errors++; $display("FAIL next_req f=%0d k=%0d got %h exp %h", f, k, dut_bus, exp_bus);
                end
                if (f == 0 && (k == kfs || k == kfs + 1)) begin
                    vectors++;
                    if (pattern_id !== ((k == kfs) ? 3'd0 : 3'd1)) begin
                        errors++; $display("FAIL next_req_edge k=%0d got %0d", k, pattern_id);
                    end
                end
                if (f == 1 && de_i && row_i == 0 && column_i == 400) begin
                    vectors++;
                    if (dut_rgb !== 24'h646464) begin
                        errors++; $display("FAIL grey_400 got %h exp 646464", dut_rgb);
                    end
                end
            end
        end
        next_req = 0;
    endtask

    task automatic test_multi_req();
        int a, k1, k2, k3, kfs;
        logic [2:0] want;
        set_geom(128, 36);
        a   = v_act * h_tot;
        kfs = (v_act + 1) * h_tot;
        k1  = $urandom_range(0, a / 3 - 1);
        k2  = $urandom_range(a / 3, 2 * a / 3 - 1);
        k3  = $urandom_range(2 * a / 3, a - 1);
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < h_tot * v_tot; k++) begin
                set_timing(k);
                next_req = (f == 0 && (k == k1 || k == k2 || k == k3)) || (f == 1 && k == kfs);
                tick();
                vectors++;
                if (dut_bus !== exp_bus) begin
                    errors++; $display("FAIL multi_req f=%0d k=%0d got %h exp %h", f, k, dut_bus, exp_bus);
                end
                if ((f > 0 && k == 0) || (f == 1 && (k == kfs || k == kfs + 1))) begin
                    want = (f == 2 || k == kfs + 1) ? 3'd3 : 3'd2;
                    vectors++;
                    if (pattern_id !== want) begin
                        errors++;
                        $display("FAIL multi_req_pid f=%0d k=%0d got %0d exp %0d", f, k, pattern_id, want);
                    end
                end
            end
        end
        next_req = 0;
    endtask

    task automatic test_auto();
        do_reset();
        set_geom(16, 2);
        auto_en = 1;
        for (int f = 0; f < 13; f++) begin
            for (int k = 0; k < h_tot * v_tot; k++) begin
                set_timing(k);
                tick();
                vectors++;
                if (dut_bus !== exp_bus) begin
                    errors++; $display("FAIL auto f=%0d k=%0d got %h exp %h", f, k, dut_bus, exp_bus);
                end
                if (f > 0 && k == 0) begin
                    vectors++;
                    if (pattern_id !== 3'(((f - 1) / 2) % 5)) begin
                        errors++;
                        $display("FAIL auto_seq f=%0d got %0d exp %0d", f, pattern_id, ((f - 1) / 2) % 5);
                    end
                end
            end
        end
        auto_en = 0;
    endtask

    task automatic test_moving_line();
        int kreq;
        logic [23:0] want;
        do_reset();
        set_geom(8, 2);
        for (int f = 0; f < 15; f++) begin
            kreq = $urandom_range(0, v_act * h_tot - 1);
            for (int k = 0; k < h_tot * v_tot; k++) begin
                set_timing(k);
                next_req = (f >= 1 && f <= 4) && (k == kreq);
                tick();
                vectors++;
                if (dut_bus !== exp_bus) begin
                    errors++; $display("FAIL line f=%0d k=%0d got %h exp %h", f, k, dut_bus, exp_bus);
                end
                if (f >= 5 && de_i) begin
                    want = (column_i == 11'((f - 5) % 8)) ? 24'hFFFFFF : 24'h0;
                    vectors++;
                    if (dut_rgb !== want || pattern_id !== 3'd4) begin
                        errors++;
                        $display("FAIL line_pos f=%0d c=%0d got %h/%0d exp %h/4",
                                 f, column_i, dut_rgb, pattern_id, want);
                    end
                end
            end
        end
        next_req = 0;
    endtask

    task automatic test_reset_mid_frame();
        int kreq, khit;
        logic [23:0] want;
        do_reset();
        set_geom(200, 4);
        kreq = $urandom_range(0, v_act * h_tot - 1);
        khit = h_tot + $urandom_range(10, 190);
        for (int f = 0; f < 6; f++) begin
            for (int k = 0; k < h_tot * v_tot; k++) begin
                set_timing(k);
                next_req = (f == 1 || f == 2) && (k == kreq);
                tick();
                vectors++;
                if (dut_bus !== exp_bus) begin
                    errors++; $display("FAIL rst_mid f=%0d k=%0d got %h exp %h", f, k, dut_bus, exp_bus);
                end
                if (f == 3 && k == khit) begin
                    vectors++;
                    if (pattern_id !== 3'd2) begin
                        errors++; $display("FAIL rst_mid_pre got %0d exp 2", pattern_id);
                    end
                    rst_n = 1'b0;
                    #1;
                    vectors++;
                    if (dut_bus !== 30'h0) begin
                        errors++; $display("FAIL rst_mid_async got %h exp 0", dut_bus);
                    end
                    @(posedge pix_clk);
                    #1;
                    vectors++;
                    if (dut_bus !== 30'h0) begin
                        errors++; $display("FAIL rst_mid_held got %h exp 0", dut_bus);
                    end
                    rst_n = 1'b1;
                    model_reset();
                end
                if (de_i && ((f == 3 && k > khit) ||
                             (f == 4 && row_i == 0 && (column_i == 0 || column_i == 160)))) begin
                    want = (f == 4 && column_i == 160) ? 24'h0000FF : 24'h0;
                    vectors++;
                    if (dut_rgb !== want || pattern_id !== 3'd0) begin
                        errors++;
                        $display("FAIL rst_mid_after f=%0d k=%0d got %h/%0d exp %h/0",
                                 f, k, dut_rgb, pattern_id, want);
                    end
                end
            end
        end
        next_req = 0;
    endtask

    task automatic test_random();
        for (int f = 0; f < 20; f++) begin
            set_geom($urandom_range(8, 40), $urandom_range(2, 6));
            auto_en = 1'($urandom_range(0, 1));
            for (int k = 0; k < h_tot * v_tot; k++) begin
                set_timing(k);
                next_req = ($urandom_range(0, 63) == 0);
                tick();
                vectors++;
                if (dut_bus !== exp_bus) begin
                    errors++; $display("FAIL random f=%0d k=%0d got %h exp %h", f, k, dut_bus, exp_bus);
                end
            end
        end
        auto_en = 0;
        next_req = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        vsync_i = 0; hsync_i = 0; de_i = 0; column_i = 0; row_i = 0;
        auto_en = 0; next_req = 0;
        exp_bus = '0;
        set_geom(16, 2);
        model_reset();
        test_reset();
        test_bars();
        test_next_req();
        test_multi_req();
        test_auto();
        test_moving_line();
        test_reset_mid_frame();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/dvi_pattern_scheduler.md
Name: dvi_pattern_scheduler

Overview:
- Frame-synchronous test-pattern controller sitting between the VESA timing generator and the dvi_tx encoder, in the pix_clk domain.
- Consumes timing-generator sync, data-enable and pixel coordinates, and generates 24-bit RGB.
- Selects among 5 patterns.
- Switches pattern only at frame boundaries, either on user request or automatically every N frames.

Parameters:
- H_ACTIVE, 1280, active pixels per line; bounds the moving-line position.
- BAR_W, 160, pixels per colour bar.
- FRAMES_PER_PATTERN, 120, frames per pattern in auto mode (>=1).
- CHK_SHIFT, 5, checkerboard square size = 2^CHK_SHIFT pixels.
- VS_ACTIVE, 1, asserted level of vsync_i.

Ports:
- pix_clk  input  1  pixel clock; all logic on rising edge.
- rst_n  input  1  reset; asynchronous assert, active-low.
- vsync_i  input  1  vertical sync from timing generator.
- hsync_i  input  1  horizontal sync from timing generator.
- de_i  input  1  data enable from timing generator.
- column_i  input  11  active-area x coordinate.
- row_i  input  11  active-area y coordinate.
- auto_en  input  1  1 = auto-advance every FRAMES_PER_PATTERN frames.
- next_req  input  1  single-cycle pulse requesting advance to the next pattern.
- vsync_o  output  1  vsync_i delayed 1 cycle.
- hsync_o  output  1  hsync_i delayed 1 cycle.
- de_o  output  1  de_i delayed 1 cycle.
- red_o  output  8  red pixel value.
- green_o  output  8  green pixel value.
- blue_o  output  8  blue pixel value.
- pattern_id  output  3  currently displayed pattern, 0..4.

Behaviour:
- Reset (rst_n=0, async): all outputs 0; pattern_id=0; frame counter=0; line_pos=0; pending request cleared; state=WAIT_SYNC.
- Latency: exactly 1 pix_clk from inputs to all outputs.
  - RGB computed combinationally from the current cycle's column_i/row_i/de_i, then registered alongside the syncs.
  - When de_i=0, the registered RGB is 0.
- Frame boundary (fs): the cycle where vsync_i transitions to VS_ACTIVE (edge detect against a registered copy of vsync_i).
- FSM:
  - WAIT_SYNC: RGB forced 0; go to RUN on first fs.
  - RUN: patterns active. On fs with advance pending, go to SWITCH.
  - SWITCH: one cycle. pattern_id <= (pattern_id==4) ? 0 : pattern_id+1; frame counter <= 0; pending cleared; return to RUN.
- Advance pending is set by either:
  - next_req=1 (any state except reset), or
  - auto_en=1 at an fs where frame counter == FRAMES_PER_PATTERN-1.
- Multiple next_req pulses within one frame collapse into a single advance.
- next_req coincident with fs: the request counts for that same fs.
- Frame counter:
  - increments on each fs in RUN; saturates at FRAMES_PER_PATTERN-1 when auto_en=0;
  - reset to 0 in SWITCH.
- Patterns (pixel at column c, row r, evaluated when de_i=1):
  - 0, colour bars:
    - bar counter and 3-bit bar index both reset to 0 while de_i=0;
    - bar counter increments each de_i cycle; when it reaches BAR_W-1 it wraps to 0 and the index increments (3-bit wrap);
    - each channel = 8 copies of one index bit: R=index[2], G=index[1], B=index[0].
  - 1, grey ramp: R=G=B=c[9:2].
  - 2, checkerboard: white (FF) if c[CHK_SHIFT]^r[CHK_SHIFT], else black.
  - 3, solid white: FFFFFF.
  - 4, moving line:
    - white where c==line_pos, else black;
    - line_pos increments on each fs while pattern_id==4, wrapping H_ACTIVE-1 -> 0;
    - line_pos cleared on entry to pattern 4.
- Reset mid-frame: outputs return to 0 immediately; the block re-enters WAIT_SYNC and waits for the next fs.

Test Plan:
- Reset, then 3 frames of 1280x720 timing with auto_en=0 and no requests -> pattern_id=0 throughout; first active pixel RGB=000000; pixel 160 RGB=0000FF; pixel 1279 RGB=FFFFFF. RGB=0 before the first fs.
- Single next_req pulse mid-frame -> pattern_id changes 0->1 exactly 1 cycle after the next fs, not earlier. Pixel c=400 gives R=G=B=0x64.
- Three next_req pulses within one frame -> exactly one advance. Also next_req coincident with fs -> advance occurs at that fs.
- FRAMES_PER_PATTERN=2, auto_en=1, 12 frames -> pattern_id sequence 0,0,1,1,2,2,3,3,4,4,0,0, covering the 4->0 wrap.
- Pattern 4 with H_ACTIVE=8 over 10 frames -> white pixel at c=0,1,...,7,0,1. Check de_o/hsync_o/vsync_o equal the inputs delayed by 1 cycle every cycle.
- Assert rst_n low mid-active-line while on pattern 2 -> all outputs 0 asynchronously. After release: RGB=0 until the next fs, then pattern_id=0 with colour bars.
